// File: rtl/csm_pkg.sv
// Shared types and default sizing for the concurrent shared memory.
package csm_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_HOLD    = 2'd2,
    OP_RELEASE = 2'd3
  } csm_op_t;

  localparam int unsigned CSM_NUM_PORTS = 2;
  localparam int unsigned CSM_ADDR_W    = 2;
  localparam int unsigned CSM_DATA_W    = 8;

  // Response payload at the default data width.
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [CSM_DATA_W-1:0] rdata;
  } csm_resp_t;

endpackage

// File: rtl/csm_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, searching upward from rr_ptr.
module csm_rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] rr_ptr;
  logic             found;

  // Pick the first requester at or after rr_ptr, wrapping past N-1 to 0.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned cand;
      cand = 32'(rr_ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[IDX_W'(cand)]) begin
        found                = 1'b1;
        gnt[IDX_W'(cand)]    = 1'b1;
        gnt_idx              = IDX_W'(cand);
      end
    end
  end

  // Pointer moves just past the grantee; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance && found) begin
      rr_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/csm_nport.sv
// N-port shared memory with per-location hold/release locks and registered responses.
module csm_nport
  import csm_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = CSM_NUM_PORTS,
  parameter  int unsigned ADDR_W    = CSM_ADDR_W,
  parameter  int unsigned DATA_W    = CSM_DATA_W,
  localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned DEPTH     = 2 ** ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_valid,
  input  csm_op_t              req_op    [NUM_PORTS],
  input  logic [ADDR_W-1:0]    req_addr  [NUM_PORTS],
  input  logic [DATA_W-1:0]    req_wdata [NUM_PORTS],
  output logic [NUM_PORTS-1:0] req_ready,
  output logic [NUM_PORTS-1:0] resp_valid,
  output logic [DATA_W-1:0]    resp_rdata [NUM_PORTS],
  output logic [NUM_PORTS-1:0] resp_err
);

  logic [DATA_W-1:0]    mem   [DEPTH];
  logic                 held  [DEPTH];
  logic [IDX_W-1:0]     owner [DEPTH];

  logic [NUM_PORTS-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  csm_op_t              sel_op;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 cur_held;
  logic [IDX_W-1:0]     cur_owner;
  logic                 foreign_lock;
  logic                 op_err;
  logic [DATA_W-1:0]    op_rdata;

  csm_rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (gnt_any),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is visible to requesters only outside reset.
  assign req_ready = rst_n ? gnt : '0;
  assign gnt_any   = |gnt;

  // Mux the granted port's request and evaluate the lock rules against it.
  assign sel_op       = req_op[gnt_idx];
  assign sel_addr     = req_addr[gnt_idx];
  assign sel_wdata    = req_wdata[gnt_idx];
  assign cur_held     = held[sel_addr];
  assign cur_owner    = owner[sel_addr];
  assign foreign_lock = cur_held && (cur_owner != gnt_idx);
  assign op_err       = (sel_op == OP_RELEASE) ? (!cur_held || (cur_owner != gnt_idx))
                                               : foreign_lock;
  assign op_rdata     = (!op_err && (sel_op == OP_READ || sel_op == OP_HOLD))
                        ? mem[sel_addr] : '0;

  // Memory and lock state; rejected ops leave everything untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]   <= '0;
        held[i]  <= 1'b0;
        owner[i] <= '0;
      end
    end else if (gnt_any && !op_err) begin
      case (sel_op)
        OP_WRITE:   mem[sel_addr] <= sel_wdata;
        OP_HOLD: begin
          held[sel_addr]  <= 1'b1;
          owner[sel_addr] <= gnt_idx;
        end
        OP_RELEASE: held[sel_addr] <= 1'b0;
        default:    ;
      endcase
    end
  end

  // One-cycle response pulse to the port granted in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_err   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) resp_rdata[p] <= '0;
    end else begin
      resp_valid <= gnt;
      resp_err   <= gnt & {NUM_PORTS{op_err}};
      for (int p = 0; p < NUM_PORTS; p++) resp_rdata[p] <= gnt[p] ? op_rdata : '0;
    end
  end

endmodule
